// File: rtl/sw_debounce.sv
// sw_debounce: per-bit synchronizer and stable-count debouncer for slide switches.
// Each bit gets its own synchronizer chain and its own stability counter. The
// clean level is accepted only after the synchronized input has disagreed with
// the current level for CNT_MAX consecutive cycles. Registered one-cycle
// rise/fall/change strobes line up with the first cycle of the new level.
module sw_debounce #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned CNT_MAX     = 1000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic [WIDTH-1:0] SW_RAW,
    output logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] SW_RISE,
    output logic [WIDTH-1:0] SW_FALL,
    output logic             SW_CHANGED
);

    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    // Stage 0 is the only flop that samples SW_RAW; the last stage is the synchronized level.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_w;

    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]            sw_q, sw_d;
    logic [WIDTH-1:0]            rise_q, rise_d;
    logic [WIDTH-1:0]            fall_q, fall_d;
    logic                        changed_q, changed_d;

    assign sync_w = sync_q[SYNC_STAGES-1];

    // Synchronizer shift chain: plain flop-to-flop, nothing in between.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], SW_RAW};
        end
    end

    // Per-bit stability counting, acceptance and edge detection.
    always_comb begin
        cnt_d = cnt_q;
        sw_d  = sw_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync_w[i] == sw_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                sw_d[i]  = sync_w[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        rise_d    = sw_d & ~sw_q;
        fall_d    = ~sw_d & sw_q;
        changed_d = |(rise_d | fall_d);
    end

    // Debounce state and strobe registers; reset restarts every channel at level 0.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cnt_q     <= '0;
            sw_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sw_q      <= sw_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign SW         = sw_q;
    assign SW_RISE    = rise_q;
    assign SW_FALL    = fall_q;
    assign SW_CHANGED = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with CNT_MAX=4, SYNC_STAGES=2, WIDTH=4.
// Inputs change and outputs are sampled 1 ns after the falling clock edge.
module tb_sw_debounce;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] sw_raw = '0;
    logic [WIDTH-1:0] sw, sw_rise, sw_fall;
    logic             sw_changed;

    int n_checks = 0;
    int n_pass   = 0;

    int rise_cnt [WIDTH];
    int fall_cnt [WIDTH];
    int chg_cnt;

    sw_debounce #(
        .WIDTH(4),
        .CNT_MAX(4),
        .SYNC_STAGES(2)
    ) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .SW_RAW    (sw_raw),
        .SW        (sw),
        .SW_RISE   (sw_rise),
        .SW_FALL   (sw_fall),
        .SW_CHANGED(sw_changed)
    );

    always #5 clk = ~clk;

    // Strobe pulse counters, sampled once per cycle on the falling edge.
    initial begin
        chg_cnt = 0;
        for (int i = 0; i < WIDTH; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < WIDTH; i++) begin
                if (sw_rise[i]) rise_cnt[i] = rise_cnt[i] + 1;
                if (sw_fall[i]) fall_cnt[i] = fall_cnt[i] + 1;
            end
            if (sw_changed) chg_cnt = chg_cnt + 1;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sw, sw_rise, sw_fall, sw_changed} !== 13'd0)
            $display("FAIL reset_async: got sw=%b rise=%b fall=%b chg=%b, need all 0", sw, sw_rise, sw_fall, sw_changed);
        else n_pass++;
        for (int k = 0; k < 3; k++) step();
        n_checks++;
        if ({sw, sw_rise, sw_fall, sw_changed} !== 13'd0)
            $display("FAIL reset_hold: got sw=%b rise=%b fall=%b chg=%b, need all 0", sw, sw_rise, sw_fall, sw_changed);
        else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    // Clean step on bit 0: accepted on the 5th edge after e1, i.e. the 6th edge counting e1.
    task automatic test_clean_step();
        int f0 = fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3];
        int r0 = rise_cnt[0];
        int c0 = chg_cnt;
        sw_raw = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            step();
            n_checks++;
            if (k <= 5 && sw !== 4'b0000)
                $display("FAIL step_sw_early edge %0d: got %b need 0000", k, sw);
            else if (k >= 6 && sw !== 4'b0001)
                $display("FAIL step_sw_late edge %0d: got %b need 0001", k, sw);
            else n_pass++;
            n_checks++;
            if (k == 6 && (sw_rise !== 4'b0001 || sw_changed !== 1'b1))
                $display("FAIL step_strobe edge %0d: got rise=%b chg=%b need 0001/1", k, sw_rise, sw_changed);
            else if (k != 6 && (sw_rise !== 4'b0000 || sw_changed !== 1'b0))
                $display("FAIL step_quiet edge %0d: got rise=%b chg=%b need 0000/0", k, sw_rise, sw_changed);
            else n_pass++;
        end
        n_checks++;
        if ((fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3]) - f0 != 0 || rise_cnt[0] - r0 != 1 || chg_cnt - c0 != 1)
            $display("FAIL step_counts: got fall=%0d rise0=%0d chg=%0d need 0/1/1",
                     (fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3]) - f0, rise_cnt[0] - r0, chg_cnt - c0);
        else n_pass++;
    endtask

    // 3-cycle pulses on bit 1 are rejected; a long hold is accepted on the 6th edge.
    task automatic test_glitch();
        int c0 = chg_cnt;
        int r0 = rise_cnt[1];
        for (int rep = 0; rep < 5; rep++) begin
            sw_raw[1] = 1'b1;
            for (int k = 0; k < 3; k++) step();
            sw_raw[1] = 1'b0;
            for (int k = 0; k < 3; k++) step();
            n_checks++;
            if (sw !== 4'b0001)
                $display("FAIL glitch_sw rep %0d: got %b need 0001", rep, sw);
            else n_pass++;
        end
        n_checks++;
        if (chg_cnt != c0 || rise_cnt[1] != r0)
            $display("FAIL glitch_strobes: got chg=%0d rise1=%0d extra pulses, need 0", chg_cnt - c0, rise_cnt[1] - r0);
        else n_pass++;
        sw_raw[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 5 || k == 6) begin
                n_checks++;
                if (sw[1] !== (k == 6))
                    $display("FAIL glitch_hold edge %0d: got sw1=%b need %b", k, sw[1], (k == 6));
                else n_pass++;
            end
        end
        n_checks++;
        if (rise_cnt[1] - r0 != 1 || sw !== 4'b0011)
            $display("FAIL glitch_hold_rise: got rise1 pulses=%0d sw=%b need 1/0011", rise_cnt[1] - r0, sw);
        else n_pass++;
    endtask

    // Bouncing bit 2 settles high; only the final run counts.
    task automatic test_bounce();
        logic [5:0] pattern = 6'b101101;
        int r0 = rise_cnt[2];
        for (int j = 5; j >= 0; j--) begin
            sw_raw[2] = pattern[j];
            if (j != 0) step();
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            n_checks++;
            if (sw[2] !== (k >= 6))
                $display("FAIL bounce_sw2 edge %0d: got %b need %b", k, sw[2], (k >= 6));
            else n_pass++;
        end
        n_checks++;
        if (rise_cnt[2] - r0 != 1)
            $display("FAIL bounce_rise: got %0d pulses need 1", rise_cnt[2] - r0);
        else n_pass++;
    endtask

    // All four bits flip on the same edge with one SW_CHANGED pulse.
    task automatic test_multi_bit();
        int c0;
        sw_raw = 4'b0101;
        for (int k = 0; k < 10; k++) step();
        n_checks++;
        if (sw !== 4'b0101)
            $display("FAIL multi_setup: got %b need 0101", sw);
        else n_pass++;
        c0 = chg_cnt;
        sw_raw = 4'b1010;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_checks++;
            if (k <= 5 && sw !== 4'b0101)
                $display("FAIL multi_sw edge %0d: got %b need 0101", k, sw);
            else if (k >= 6 && sw !== 4'b1010)
                $display("FAIL multi_sw edge %0d: got %b need 1010", k, sw);
            else n_pass++;
            if (k == 6) begin
                n_checks++;
                if (sw_rise !== 4'b1010 || sw_fall !== 4'b0101 || sw_changed !== 1'b1)
                    $display("FAIL multi_strobe: got rise=%b fall=%b chg=%b need 1010/0101/1", sw_rise, sw_fall, sw_changed);
                else n_pass++;
            end
        end
        n_checks++;
        if (chg_cnt - c0 != 1)
            $display("FAIL multi_chg_count: got %0d need 1", chg_cnt - c0);
        else n_pass++;
    endtask

    // Reset mid-count clears SW without a clock edge and restarts all counters.
    task automatic test_reset_mid_count();
        int r0 [WIDTH];
        int c0;
        sw_raw = 4'b1111;
        for (int k = 0; k < 4; k++) step();
        n_checks++;
        if (sw !== 4'b1010)
            $display("FAIL midrst_pre: got %b need 1010", sw);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sw !== 4'b0000)
            $display("FAIL midrst_async: got %b need 0000", sw);
        else n_pass++;
        step();
        step();
        for (int i = 0; i < WIDTH; i++) r0[i] = rise_cnt[i];
        c0 = chg_cnt;
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            n_checks++;
            if (k <= 5 && sw !== 4'b0000)
                $display("FAIL midrst_sw edge %0d: got %b need 0000", k, sw);
            else if (k >= 6 && sw !== 4'b1111)
                $display("FAIL midrst_sw edge %0d: got %b need 1111", k, sw);
            else n_pass++;
            if (k == 6) begin
                n_checks++;
                if (sw_rise !== 4'b1111 || sw_changed !== 1'b1)
                    $display("FAIL midrst_strobe: got rise=%b chg=%b need 1111/1", sw_rise, sw_changed);
                else n_pass++;
            end
        end
        n_checks++;
        if (rise_cnt[0] - r0[0] != 1 || rise_cnt[1] - r0[1] != 1 || rise_cnt[2] - r0[2] != 1
            || rise_cnt[3] - r0[3] != 1 || chg_cnt - c0 != 1)
            $display("FAIL midrst_counts: got rise=%0d,%0d,%0d,%0d chg=%0d need 1 each",
                     rise_cnt[0] - r0[0], rise_cnt[1] - r0[1], rise_cnt[2] - r0[2], rise_cnt[3] - r0[3], chg_cnt - c0);
        else n_pass++;
    endtask

    // Sweep every value, 10 cycles each; each value must be held and change once.
    task automatic test_sweep();
        for (int v = 0; v < 16; v++) begin
            int c0 = chg_cnt;
            int held = 0;
            sw_raw = 4'(v);
            for (int k = 0; k < 10; k++) begin
                step();
                if (sw === 4'(v)) held++;
            end
            n_checks++;
            if (held < 4 || sw !== 4'(v))
                $display("FAIL sweep_hold v=%0d: got sw=%b held %0d cycles need %b for >=4", v, sw, held, 4'(v));
            else n_pass++;
            n_checks++;
            if (chg_cnt - c0 != 1)
                $display("FAIL sweep_chg v=%0d: got %0d pulses need 1", v, chg_cnt - c0);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_multi_bit();
        test_reset_mid_count();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
